// File: rtl/divisor_pkg.sv
// Shared types and constants for the programmable clock-enable divider bank.
package divisor_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } canal_state_e;

    localparam logic ModeCont    = 1'b0;
    localparam logic ModeOneShot = 1'b1;

endpackage

// File: rtl/divisor_canal.sv
// One divider channel: counts CE pulses up to a programmable terminal value and ticks on wrap.
module divisor_canal
    import divisor_pkg::*;
#(
    parameter int unsigned BITS       = 8,
    parameter int unsigned MAX_CUENTA = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic            START,
    input  logic            ONE_SHOT,
    input  logic            WE,
    input  logic [BITS-1:0] WR_MOD,
    output logic [BITS-1:0] CUENTA,
    output logic            FIN_CUENTA,
    output logic            ACTIVO
);

    canal_state_e    state_q, state_d;
    logic [BITS-1:0] cuenta_q, cuenta_d;
    logic [BITS-1:0] shadow_q, shadow_d;
    logic [BITS-1:0] mod_q, mod_d;
    logic [BITS-1:0] next_mod;
    logic            wrap;

    // A write landing on the same edge as a reload goes straight to the active modulus.
    assign next_mod = WE ? WR_MOD : shadow_q;

    // >= rather than == so a corrupted count still wraps instead of running to overflow.
    assign wrap = (state_q == StRun) && CE && !START && (cuenta_q >= mod_q);

    always_comb begin
        state_d  = state_q;
        cuenta_d = cuenta_q;
        shadow_d = WE ? WR_MOD : shadow_q;
        mod_d    = mod_q;

        unique case (state_q)
            StIdle: begin
                cuenta_d = '0;
                if (START) begin
                    state_d = StRun;
                    mod_d   = next_mod;
                end
            end
            StRun: begin
                if (START) begin
                    cuenta_d = '0;
                    mod_d    = next_mod;
                end else if (wrap) begin
                    cuenta_d = '0;
                    mod_d    = next_mod;
                    unique case (ONE_SHOT)
                        ModeOneShot: state_d = StIdle;
                        ModeCont:    state_d = StRun;
                        default:     state_d = StRun;
                    endcase
                end else if (CE) begin
                    cuenta_d = cuenta_q + BITS'(1);
                end
            end
            default: begin
                state_d  = StIdle;
                cuenta_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            cuenta_q <= '0;
            shadow_q <= BITS'(MAX_CUENTA);
            mod_q    <= BITS'(MAX_CUENTA);
        end else begin
            state_q  <= state_d;
            cuenta_q <= cuenta_d;
            shadow_q <= shadow_d;
            mod_q    <= mod_d;
        end
    end

    assign CUENTA     = cuenta_q;
    assign FIN_CUENTA = wrap;
    assign ACTIVO     = (state_q == StRun);

endmodule

// File: rtl/divisor_multi.sv
// N_CH-channel programmable prescaler bank: write-channel decode plus one divisor_canal per channel.
module divisor_multi
    import divisor_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned BITS       = 8,
    parameter int unsigned MAX_CUENTA = 5,
    parameter int unsigned CH_BITS    = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_CH-1:0]      CE,
    input  logic [N_CH-1:0]      START,
    input  logic [N_CH-1:0]      ONE_SHOT,
    input  logic                 WE,
    input  logic [CH_BITS-1:0]   WR_CH,
    input  logic [BITS-1:0]      WR_MOD,
    output logic [N_CH*BITS-1:0] CUENTA,
    output logic [N_CH-1:0]      FIN_CUENTA,
    output logic [N_CH-1:0]      ACTIVO
);

    logic [N_CH-1:0] we_ch;

    // Indices at or beyond N_CH match no channel, so such writes fall on the floor.
    always_comb begin
        we_ch = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            we_ch[i] = WE && (32'(WR_CH) == i);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_canal
        divisor_canal #(
            .BITS      (BITS),
            .MAX_CUENTA(MAX_CUENTA)
        ) u_canal (
            .CLK       (CLK),
            .RST       (RST),
            .CE        (CE[g]),
            .START     (START[g]),
            .ONE_SHOT  (ONE_SHOT[g]),
            .WE        (we_ch[g]),
            .WR_MOD    (WR_MOD),
            .CUENTA    (CUENTA[g*BITS +: BITS]),
            .FIN_CUENTA(FIN_CUENTA[g]),
            .ACTIVO    (ACTIVO[g])
        );
    end

endmodule
